// File: rtl/fifo_ctl_512x8.sv
// Single-clock FIFO controller for a 512x8 block RAM with a 2-entry output skid buffer.
// Optional AlmostFull output enabled by defining FIFO_AFULL_EN.
module fifo_ctl_512x8 #(
  parameter int unsigned ADDR_W = 9
`ifdef FIFO_AFULL_EN
  , parameter int unsigned AFULL_LVL = 448
`endif
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Push,
  input  logic [7:0]        PushData,
  output logic              Full,
  output logic              PopValid,
  input  logic              PopReady,
  output logic [7:0]        PopData,
  output logic [ADDR_W:0]   Level,
  output logic              Overflow,
  output logic [ADDR_W-1:0] RAM_WA,
  output logic [7:0]        RAM_WD,
  output logic              RAM_WEN,
  output logic [ADDR_W-1:0] RAM_RA,
  output logic              RAM_RClk_En,
  input  logic [7:0]        RAM_RD
`ifdef FIFO_AFULL_EN
  , output logic            AlmostFull
`endif
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [PTR_W-1:0] wptr, rptr, wptr_n, rptr_n;
  logic             rd_pend, rd_pend_n;
  logic             h0_v, h1_v, h0_v_n, h1_v_n;
  logic [7:0]       h0_d, h1_d, h0_d_n, h1_d_n;
  logic             overflow_n;

  logic [PTR_W-1:0] ram_cnt;
  logic [1:0]       skid_cnt;
  logic [LVL_W-1:0] level;
  logic             full, push_ok, pop_fire, rd_en;

  // Occupancy counts everything held: RAM, the read in flight and the skid entries.
  assign ram_cnt  = wptr - rptr;
  assign skid_cnt = {1'b0, h0_v} + {1'b0, h1_v};
  assign level    = LVL_W'(ram_cnt) + LVL_W'(rd_pend) + LVL_W'(skid_cnt);
  assign full     = (level == LVL_W'(DEPTH));
  assign pop_fire = h0_v & PopReady;
  assign push_ok  = Push & ~full;
  // Issue a read only if the skid buffer will have room for its data after this edge.
  assign rd_en    = (ram_cnt != '0) &&
                    ((3'(skid_cnt) + 3'(rd_pend) - 3'(pop_fire)) < 3'd2);

  always_comb begin
    wptr_n     = wptr + PTR_W'(push_ok);
    rptr_n     = rptr + PTR_W'(rd_en);
    rd_pend_n  = rd_en;
    overflow_n = Overflow | (Push & full);
    h0_v_n     = h0_v;
    h0_d_n     = h0_d;
    h1_v_n     = h1_v;
    h1_d_n     = h1_d;
    if (pop_fire) begin
      h0_v_n = h1_v;
      h0_d_n = h1_d;
      h1_v_n = 1'b0;
    end
    if (rd_pend) begin
      if (!h0_v_n) begin
        h0_v_n = 1'b1;
        h0_d_n = RAM_RD;
      end else begin
        h1_v_n = 1'b1;
        h1_d_n = RAM_RD;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_pend  <= 1'b0;
      h0_v     <= 1'b0;
      h1_v     <= 1'b0;
      h0_d     <= '0;
      h1_d     <= '0;
      Overflow <= 1'b0;
    end else begin
      wptr     <= wptr_n;
      rptr     <= rptr_n;
      rd_pend  <= rd_pend_n;
      h0_v     <= h0_v_n;
      h1_v     <= h1_v_n;
      h0_d     <= h0_d_n;
      h1_d     <= h1_d_n;
      Overflow <= overflow_n;
    end
  end

`ifdef FIFO_AFULL_EN
  logic [LVL_W-1:0] level_n;
  logic             afull_n;

  // Next-cycle level: pushes add, pops remove; RAM-to-skid moves are level-neutral.
  assign level_n = level + LVL_W'(push_ok) - LVL_W'(pop_fire);
  assign afull_n = (level_n >= LVL_W'(AFULL_LVL));

  always_ff @(posedge Clk) begin
    if (Rst) AlmostFull <= 1'b0;
    else     AlmostFull <= afull_n;
  end
`endif

  assign Full        = full;
  assign Level       = level;
  assign PopValid    = h0_v;
  assign PopData     = h0_d;
  assign RAM_WA      = wptr[ADDR_W-1:0];
  assign RAM_WD      = PushData;
  assign RAM_WEN     = push_ok;
  assign RAM_RA      = rptr[ADDR_W-1:0];
  assign RAM_RClk_En = rd_en;

endmodule

// File: doc/fifo_ctl_512x8.md
Name: fifo_ctl_512x8

Overview:
Single-clock FIFO controller that drives the 512x8 block-RAM macro of the usb2serial datapath. It sits directly upstream of the RAM, owning write/read addresses and enables. It takes bytes from the USB endpoint side (push interface) and returns them, in order, to the UART transmitter through a valid/ready pop interface. It absorbs the RAM's 1-cycle read latency with a 2-entry output skid buffer.

Parameters:
ADDR_W, 9, RAM address width; depth = 2**ADDR_W = 512.
AFULL_LVL, 448, almost-full threshold; used only with FIFO_AFULL_EN.

Ports:
Clk  in  1  sole clock; RAM WClk and RClk are tied to it externally.
Rst  in  1  synchronous, active-high reset.
Push  in  1  write request; accepted on a Clk edge when Full=0.
PushData  in  8  byte to store.
Full  out  1  Level == 512.
PopValid  out  1  head byte available on PopData.
PopReady  in  1  consumer takes head when PopValid & PopReady.
PopData  out  8  head byte.
Level  out  10  total bytes held: RAM + in-flight read + skid, range 0..512.
Overflow  out  1  sticky; set by Push while Full.
RAM_WA  out  9  RAM write address = wptr[8:0].
RAM_WD  out  8  = PushData.
RAM_WEN  out  1  = Push & ~Full.
RAM_RA  out  9  RAM read address = rptr[8:0].
RAM_RClk_En  out  1  read issue strobe.
RAM_RD  in  8  RAM read data, valid the cycle after the RAM_RClk_En edge.

Behaviour:
- Reset: wptr=rptr=0 (10-bit, wrap bit included), skid empty, rd_pend=0, Overflow=0. Consequently PopValid=0, Full=0, Level=0, RAM_WEN=0, RAM_RClk_En=0. RAM contents are not cleared. A reset mid-operation discards all data, including an in-flight read.
- Write path: on an accepted push, RAM writes at wptr, then wptr+1 modulo 1024. Full is evaluated from pre-edge state. Push+PopReady while Full: push rejected, pop proceeds, Overflow sets.
- RAM occupancy: ram_cnt = wptr - rptr, computed modulo 1024. A byte written at edge E can be read no earlier than the cycle after E, so there is no same-address read/write collision.
- Read issue (combinational): RAM_RClk_En = (ram_cnt != 0) & (skid_cnt + rd_pend - pop_fire < 2). On the edge where it is high, rptr increments and rd_pend is set to 1. Otherwise rd_pend is cleared on that edge.
- Skid buffer: entries h0 (head) and h1. While rd_pend=1, RAM_RD is loaded at the next edge into h0 if h0 will be empty after this edge's pop, otherwise into h1. On a pop, h1 shifts into h0. PopValid = h0 valid, PopData = h0 data.
- Latency: push accepted at edge E0 → read issued in the cycle after E0 → PopValid high after E2 (2 cycles, first word). Sustained throughput is 1 byte/cycle with PopReady held high.
- Level = ram_cnt + rd_pend + skid_cnt, registered-state arithmetic, 10 bits. Full = (Level == 512). Level never exceeds 512 because RAM slots are freed only when their byte moves into the read pipeline.
- Empty: pop with PopValid=0 is ignored, and there are no state changes on the pop side.
- Wrap: pointers wrap 1023→0. The address bits wrap 511→0 without discontinuity.

Optional Feature:
FIFO_AFULL_EN. When defined, the block adds output port AlmostFull (1 bit), which is registered and set when next-cycle Level >= AFULL_LVL. It resets to 0. When FIFO_AFULL_EN is undefined, the port and its logic are absent and AFULL_LVL is unused.

Test Plan:
- Reset then idle → PopValid=0, Level=0, Full=0, RAM_WEN=0, RAM_RClk_En=0 for 10 cycles.
- Push 0xA5 at edge 0 with PopReady=0 → RAM_WA=0 write; PopValid=1, PopData=0xA5 after edge 2; Level=1 throughout.
- Push 512 bytes 0x00..0xFF twice with PopReady=0 → Full=1 at Level=512. A 513th push sets Overflow=1 and stored data is unchanged. Draining yields the exact sequence.
- Push and pop continuously at 1/cycle for 2000 bytes (incrementing pattern) → no gaps after first-word latency, data in order, RAM_RA wraps 511→0 correctly, Level stays ≤3.
- Random PopReady toggling with bursty pushes → scoreboard matches. PopData is stable while PopValid & ~PopReady.
- Assert Rst with 100 bytes queued and a read in flight → next cycle Level=0, PopValid=0, Overflow=0. A subsequent push of 0x3C is returned first.
- With FIFO_AFULL_EN, AFULL_LVL=448: fill to 447 → AlmostFull=0. The 448th push → AlmostFull=1 the following cycle. Pop one → AlmostFull=0.
